window_ctrl: RTL and testbench
==============================

WINDOW_CTRL -- requirements
Module: window_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_W, default 640, pixels per line (>= KERNEL).
REQ-002 SHALL have parameter IMAGE_H, default 480, lines per frame (>= KERNEL).
REQ-003 SHALL have parameter KERNEL, default 3, odd filter window size; HALF = (KERNEL-1)/2.
REQ-004 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have in_valid  input  1  upstream pixel valid.
REQ-007 SHALL have in_sop  input  1  first pixel of frame, qualified by in_valid.
REQ-008 SHALL have in_eop  input  1  last pixel of frame, qualified by in_valid.
REQ-009 SHALL have in_ready  output  1  upstream beat accepted when in_valid & in_ready.
REQ-010 SHALL have out_ready  input  1  downstream can take a window.
REQ-011 SHALL have shift_en  output  1  advance all row buffers and window registers this cycle.
REQ-012 SHALL have out_valid  output  1  window centred on (out_x, out_y) is valid.
REQ-013 SHALL have out_sop, out_eop  output  1 each  first/last window of frame, qualified by out_valid.
REQ-014 SHALL have out_x  output  $clog2(IMAGE_W)  and out_y  output  $clog2(IMAGE_H)  centre pixel coordinates.
REQ-015 SHALL have out_border  output  1  window overlaps image edge (x<HALF, x>IMAGE_W-1-HALF, y<HALF or y>IMAGE_H-1-HALF).
REQ-016 SHALL have err  output  1  one-cycle pulse on framing error.

Function
REQ-017 SHALL implement states IDLE, FILL, RUN, FLUSH; pipeline latency L = HALF*IMAGE_W + HALF accepted beats.
REQ-018 IDLE: in_ready=1; beats without in_sop dropped (shift_en=0); accepted beat with in_sop -> shift_en=1, in_count=1, go FILL (or RUN if L=0).
REQ-019 FILL: in_ready=1, out_valid=0; each accepted beat asserts shift_en, increments in_count; after L-th accepted beat go RUN.
REQ-020 RUN: in_ready=out_ready; accepted beat asserts shift_en and out_valid in the same cycle; no beat -> shift_en=0, out_valid=0.
REQ-021 FLUSH: in_ready=0; when out_ready=1, shift_en=1 and out_valid=1 (zero-pad data); remaining counter decrements from L; at 0 go IDLE.
REQ-022 Accepted in_eop in FILL or RUN SHALL go FLUSH the next cycle; it is counted as a normal beat.
REQ-023 out_x/out_y SHALL start at (0,0) on first output, increment x per output, wrap x to 0 and increment y at IMAGE_W-1; reset to (0,0) at frame end.
REQ-024 out_sop SHALL assert on output (0,0); out_eop on output (IMAGE_W-1, IMAGE_H-1), which is always the last FLUSH output.
REQ-025 out_border combinational from out_x/out_y.
REQ-026 Accepted in_sop in FILL/RUN SHALL pulse err, restart: in_count=1, output counters cleared, state FILL; partial frame discarded, no out_eop.
REQ-027 in_eop when in_count != IMAGE_W*IMAGE_H SHALL pulse err; FLUSH still runs, out_eop only if coordinates reach the last pixel.
REQ-028 Accepted beats beyond IMAGE_W*IMAGE_H without in_eop SHALL pulse err and be dropped (shift_en=0) until in_eop, then FLUSH.
REQ-029 in_sop and in_eop on the same beat SHALL be treated as sop then error (err pulse, FLUSH).
REQ-030 Counters SHALL be sized to hold IMAGE_W*IMAGE_H without overflow.

Reset
REQ-031 rst=1 SHALL force state IDLE, all counters 0, shift_en=0, out_valid=0, out_sop=0, out_eop=0, err=0, out_x=out_y=0, in_ready=0 during reset.
REQ-032 rst mid-frame SHALL abandon the frame; first cycle after release in IDLE with in_ready=1.

Verification (IMAGE_W=4, IMAGE_H=3, KERNEL=3, L=5)
REQ-033 Clean frame, 12 beats back-to-back, out_ready=1 -> shift_en 17 cycles, out_valid from beat 6, 12 outputs, out_sop at (0,0), out_eop at (3,2).
REQ-034 out_ready low 3 cycles in RUN -> in_ready=0, shift_en=0, no beat lost; output count still 12.
REQ-035 in_eop on beat 8 -> err pulse, FLUSH 5 cycles, no out_eop, back to IDLE.
REQ-036 in_sop on beat 7 -> err pulse, restart; next 12 beats with in_eop give a clean 12-output frame.
REQ-037 rst asserted during FLUSH -> IDLE next cycle, all outputs 0; subsequent clean frame matches REQ-033.
REQ-038 out_border checked for all 12 outputs: 0 only at (1,1) and (2,1).

Source files
------------

// File: rtl/window_ctrl.sv
// Sliding-window sequencer: gates row-buffer shifts and tags centre coordinates; L = HALF*IMAGE_W+HALF beats in, then one window per beat.
// Backpressure: in_ready follows out_ready once windows flow; the tail flush stalls on out_ready with upstream held off.
module window_ctrl #(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480,
    parameter int KERNEL  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sop,
    input  logic                       in_eop,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       shift_en,
    output logic                       out_valid,
    output logic                       out_sop,
    output logic                       out_eop,
    output logic [$clog2(IMAGE_W)-1:0] out_x,
    output logic [$clog2(IMAGE_H)-1:0] out_y,
    output logic                       out_border,
    output logic                       err
);
    localparam int HALF = (KERNEL - 1) / 2;
    localparam int L    = HALF * IMAGE_W + HALF;
    localparam int NPIX = IMAGE_W * IMAGE_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int XW   = $clog2(IMAGE_W);
    localparam int YW   = $clog2(IMAGE_H);

    localparam logic [CW-1:0] L_C    = CW'(L);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMAGE_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMAGE_H - 1);
    localparam logic [XW-1:0] X_LO   = XW'(HALF);
    localparam logic [XW-1:0] X_HI   = XW'(IMAGE_W - 1 - HALF);
    localparam logic [YW-1:0] Y_LO   = YW'(HALF);
    localparam logic [YW-1:0] Y_HI   = YW'(IMAGE_H - 1 - HALF);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    localparam state_t AFTER_SOP = (L <= 1) ? RUN : FILL;
    localparam state_t AFTER_EOP = (L == 0) ? IDLE : FLUSH;

    state_t          state;
    logic [CW-1:0]   in_count;
    logic [CW-1:0]   remain;
    logic [CW-1:0]   next_count;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic            ready_c;
    logic            accept;
    logic            overflow;
    logic            shift_c;
    logic            valid_c;
    logic            err_c;

    always_comb begin
        ready_c    = 1'b0;
        shift_c    = 1'b0;
        valid_c    = 1'b0;
        err_c      = 1'b0;
        next_count = in_count + 1'b1;
        // A full frame already counted: further beats are surplus and never shifted in.
        overflow   = (state == RUN) && (in_count == NPIX_C);
        if (!rst) begin
            case (state)
                IDLE, FILL: ready_c = 1'b1;
                RUN:        ready_c = out_ready;
                default:    ready_c = 1'b0;
            endcase
        end
        accept = in_valid & ready_c;
        case (state)
            IDLE: begin
                shift_c = accept & in_sop;
                err_c   = accept & in_sop & in_eop;
            end
            FILL, RUN: begin
                if (accept) begin
                    if (in_sop) begin
                        shift_c = 1'b1;
                        err_c   = 1'b1;
                    end else if (overflow) begin
                        err_c = 1'b1;
                    end else begin
                        shift_c = 1'b1;
                        valid_c = (state == RUN);
                        err_c   = in_eop && (next_count != NPIX_C);
                    end
                end
            end
            default: begin
                shift_c = out_ready & ~rst;
                valid_c = out_ready & ~rst;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_count <= '0;
            remain   <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            if (valid_c) begin
                if (x_q == X_MAX) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            case (state)
                IDLE, FILL, RUN: begin
                    if (accept && (in_sop || state != IDLE)) begin
                        if (in_sop) begin
                            // New frame (or restart): any partial frame in flight is dropped.
                            in_count <= ONE_C;
                            x_q      <= '0;
                            y_q      <= '0;
                            state    <= AFTER_SOP;
                        end else if (!overflow) begin
                            in_count <= next_count;
                            if (state == FILL && next_count == L_C)
                                state <= RUN;
                        end
                        if (in_eop) begin
                            state  <= AFTER_EOP;
                            remain <= L_C;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        remain <= remain - 1'b1;
                        if (remain == ONE_C) begin
                            state    <= IDLE;
                            in_count <= '0;
                            x_q      <= '0;
                            y_q      <= '0;
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready   = ready_c;
    assign shift_en   = shift_c;
    assign out_valid  = valid_c;
    assign err        = err_c;
    assign out_x      = rst ? '0 : x_q;
    assign out_y      = rst ? '0 : y_q;
    assign out_sop    = valid_c && (x_q == '0) && (y_q == '0);
    assign out_eop    = valid_c && (x_q == X_MAX) && (y_q == Y_MAX);
    assign out_border = (out_x < X_LO) || (out_x > X_HI) || (out_y < Y_LO) || (out_y > Y_HI);

endmodule

// File: tb/tb_window_ctrl.sv
// Bench for window_ctrl at 4x3, 3x3 kernel: count-based reference model plus directed frame scenarios and random framing.
module tb_window_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int K    = 3;
    localparam int HALF = (K - 1) / 2;
    localparam int L    = HALF * W + HALF;
    localparam int NPIX = W * H;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_sop;
    logic       in_eop;
    logic       in_ready;
    logic       out_ready;
    logic       shift_en;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic [1:0] out_x;
    logic [1:0] out_y;
    logic       out_border;
    logic       err;

    window_ctrl #(.IMAGE_W(W), .IMAGE_H(H), .KERNEL(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_ready(in_ready), .out_ready(out_ready), .shift_en(shift_en),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_x(out_x), .out_y(out_y), .out_border(out_border), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: frame open, beats counted, windows emitted, flush windows still owed.
    bit m_active = 0;
    int m_n = 0;
    int m_k = 0;
    int m_flush = 0;

    int  obs_shift, obs_out, obs_eop, obs_sop, obs_err, obs_inner;
    int  frame_cyc;
    int  rpct = 100;
    int  stall_from = 0;
    int  stall_len = 0;
    bit  seen_ready;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit rdy_now();
        if (stall_len > 0 && frame_cyc >= stall_from && frame_cyc < stall_from + stall_len)
            return 1'b0;
        return ($urandom_range(99) < rpct);
    endfunction

    task automatic clr_obs();
        obs_shift = 0; obs_out = 0; obs_eop = 0; obs_sop = 0; obs_err = 0; obs_inner = 0;
        frame_cyc = 0;
    endtask

    task automatic tick();
        bit e_rdy, e_shift, e_vld, e_err, e_sop, e_eop, e_bord, acc;
        int ex, ey;
        @(negedge clk);
        e_rdy = 0; e_shift = 0; e_vld = 0; e_err = 0; acc = 0; ex = 0; ey = 0;
        if (!rst) begin
            e_rdy = (m_flush > 0) ? 1'b0 : ((m_active && m_n >= L) ? out_ready : 1'b1);
            acc = in_valid && e_rdy;
            if (m_flush > 0) begin
                e_shift = out_ready;
                e_vld   = out_ready;
            end else if (!m_active) begin
                e_shift = acc && in_sop;
                e_err   = acc && in_sop && in_eop;
            end else if (acc) begin
                if (in_sop) begin
                    e_shift = 1; e_err = 1;
                end else if (m_n == NPIX) begin
                    e_err = 1;
                end else begin
                    e_shift = 1;
                    e_vld   = (m_n >= L);
                    e_err   = in_eop && (m_n + 1 != NPIX);
                end
            end
            ex = m_k % W;
            ey = (m_k / W) % H;
        end
        e_sop  = e_vld && (m_k == 0);
        e_eop  = e_vld && (m_k == NPIX - 1);
        e_bord = (ex < HALF) || (ex > W - 1 - HALF) || (ey < HALF) || (ey > H - 1 - HALF);
        chk("in_ready", in_ready, e_rdy);
        chk("shift_en", shift_en, e_shift);
        chk("out_valid", out_valid, e_vld);
        chk("out_sop", out_sop, e_sop);
        chk("out_eop", out_eop, e_eop);
        chk("err", err, e_err);
        chk("out_x", out_x, ex);
        chk("out_y", out_y, ey);
        chk("out_border", out_border, e_bord);
        seen_ready = in_ready;
        obs_shift += shift_en;
        obs_out   += out_valid;
        obs_eop   += (out_valid && out_eop);
        obs_sop   += (out_valid && out_sop);
        obs_err   += err;
        obs_inner += (out_valid && !out_border);
        frame_cyc++;
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_n = 0; m_k = 0; m_flush = 0;
        end else if (m_flush > 0) begin
            if (out_ready) begin
                m_k++;
                m_flush--;
                if (m_flush == 0) begin
                    m_active = 0; m_n = 0; m_k = 0;
                end
            end
        end else if (!m_active) begin
            if (acc && in_sop) begin
                m_active = 1; m_n = 1; m_k = 0;
                if (in_eop) m_flush = L;
            end
        end else if (acc) begin
            if (in_sop) begin
                m_n = 1; m_k = 0;
            end else if (m_n < NPIX) begin
                if (m_n >= L) m_k++;
                m_n++;
            end
            if (in_eop) m_flush = L;
        end
        #1;
    endtask

    task automatic drive_frame(input int nb, input int sop_at, input int eop_at, input int vpct);
        int b;
        bit done;
        for (int i = 0; i < nb; i++) begin
            b = 0;
            done = 0;
            while (!done && b < 64) begin
                in_valid = ($urandom_range(99) < vpct);
                if (in_valid) begin
                    in_sop = (i == 0) || (i == sop_at);
                    in_eop = (i == eop_at);
                end else begin
                    in_sop = $urandom_range(1);
                    in_eop = $urandom_range(1);
                end
                out_ready = rdy_now();
                tick();
                done = in_valid && seen_ready;
                b++;
            end
            if (!done) begin
                chk("beat_timeout", 0, 1);
                break;
            end
        end
        in_valid = 0; in_sop = 0; in_eop = 0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        in_valid = 0;
        while ((m_active || m_flush > 0) && c < 100) begin
            in_sop = $urandom_range(1);
            in_eop = $urandom_range(1);
            out_ready = rdy_now();
            tick();
            c++;
        end
        if (c >= 100) chk("drain_timeout", 1, 0);
        in_sop = 0; in_eop = 0;
    endtask

    initial begin
        int typ, e, s;
        rst = 1; in_valid = 0; in_sop = 0; in_eop = 0; out_ready = 1;
        clr_obs();
        tick();
        tick();
        rst = 0;
        tick();

        // Clean frame, back-to-back, no backpressure.
        clr_obs(); rpct = 100; stall_len = 0;
        drive_frame(12, -1, 11, 100);
        drain();
        chk("clean_shifts", obs_shift, 17);
        chk("clean_outs", obs_out, 12);
        chk("clean_sops", obs_sop, 1);
        chk("clean_eops", obs_eop, 1);
        chk("clean_errs", obs_err, 0);
        chk("clean_inner", obs_inner, 2);

        // Downstream stall for 3 cycles while windows flow.
        clr_obs(); stall_from = 7; stall_len = 3;
        drive_frame(12, -1, 11, 100);
        drain();
        stall_len = 0;
        chk("stall_shifts", obs_shift, 17);
        chk("stall_outs", obs_out, 12);
        chk("stall_eops", obs_eop, 1);

        // Early end of frame on beat 8.
        clr_obs();
        drive_frame(8, -1, 7, 100);
        drain();
        chk("early_outs", obs_out, 8);
        chk("early_errs", obs_err, 1);
        chk("early_eops", obs_eop, 0);
        chk("early_shifts", obs_shift, 13);

        // Restart on beat 7, then a full 12-beat frame.
        clr_obs();
        drive_frame(18, 6, 17, 100);
        drain();
        chk("restart_errs", obs_err, 1);
        chk("restart_outs", obs_out, 13);
        chk("restart_sops", obs_sop, 2);
        chk("restart_eops", obs_eop, 1);

        // Reset during the tail flush, then a clean frame.
        drive_frame(12, -1, 11, 100);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        clr_obs();
        drive_frame(12, -1, 11, 100);
        drain();
        chk("postrst_shifts", obs_shift, 17);
        chk("postrst_outs", obs_out, 12);
        chk("postrst_eops", obs_eop, 1);

        for (int f = 0; f < 60; f++) begin
            typ  = $urandom_range(6);
            rpct = 40 + $urandom_range(60);
            e    = 50 + $urandom_range(50);
            case (typ)
                0: drive_frame(12, -1, 11, e);
                1: begin s = $urandom_range(10); drive_frame(s + 1, -1, s, e); end
                2: begin s = 13 + $urandom_range(2); drive_frame(s, -1, s - 1, e); end
                3: begin s = 1 + $urandom_range(10); drive_frame(s + 12, s, s + 11, e); end
                4: drive_frame(1, -1, 0, e);
                5: begin
                    in_valid = 1; in_sop = 0; in_eop = $urandom_range(1);
                    tick();
                    tick();
                    drive_frame(12, -1, 11, e);
                end
                default: begin
                    drive_frame(2 + $urandom_range(8), -1, -1, e);
                    rst = 1;
                    tick();
                    rst = 0;
                end
            endcase
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
